// File: rtl/layer_compositor.sv
// Per-pixel layer compositor: priority-resolves layer hits, looks up a writable palette and
// applies the game-over fade / LFSR noise sequence, with a two-stage registered pipeline.
module layer_compositor #(
    parameter int                    NUM_LAYERS       = 8,
    parameter int                    COLOR_BITS       = 8,
    parameter int                    LFSR_WIDTH       = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS        = 16'h8016,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED        = 16'h0F0F,
    parameter int                    FADE_STEP_FRAMES = 4,
    parameter int                    AW               = $clog2(NUM_LAYERS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_LAYERS-1:0]   layer_hit,
    input  logic [NUM_LAYERS-1:0]   noise_mask,
    input  logic                    display_area,
    input  logic                    frame_start,
    input  logic                    game_over,
    input  logic                    pal_we,
    input  logic [AW-1:0]           pal_addr,
    input  logic [3*COLOR_BITS-1:0] pal_data,
    output logic [COLOR_BITS-1:0]   VGA_R,
    output logic [COLOR_BITS-1:0]   VGA_G,
    output logic [COLOR_BITS-1:0]   VGA_B,
    output logic                    pix_valid,
    output logic [1:0]              mode
);

    localparam int SW = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int CW = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam int PW = 3 * COLOR_BITS;

    localparam logic [1:0] MODE_RUN  = 2'd0;
    localparam logic [1:0] MODE_FADE = 2'd1;
    localparam logic [1:0] MODE_DEAD = 2'd2;

    logic [1:0]            mode_q, mode_d;
    logic [SW-1:0]         shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [NUM_LAYERS-1:0] eff_hit;
    logic [AW-1:0]         idx_d, idx_q;
    logic                  da_q;
    logic [2:0]            lb_q;
    logic [PW-1:0]         pal_q [NUM_LAYERS+1];
    logic [PW-1:0]         entry;
    logic [COLOR_BITS-1:0] r_d, g_d, b_d;

    assign mode = mode_q;

    // An all-zero register would lock up, so it reloads the seed instead of shifting.
    always_comb begin
        if (lfsr_q == '0) lfsr_d = LFSR_SEED;
        else              lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_comb begin
        eff_hit = layer_hit;
        if (mode_q == MODE_DEAD && !lfsr_q[0]) eff_hit = layer_hit & ~noise_mask;
        idx_d = AW'(NUM_LAYERS);
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eff_hit[i]) idx_d = AW'(i);
        end
    end

    always_comb begin
        entry = pal_q[idx_q];
        r_d   = entry[PW-1 -: COLOR_BITS];
        g_d   = entry[2*COLOR_BITS-1 -: COLOR_BITS];
        b_d   = entry[COLOR_BITS-1:0];
        if (mode_q == MODE_FADE) begin
            r_d = r_d >> shift_q;
            g_d = g_d >> shift_q;
            b_d = b_d >> shift_q;
        end
        if (mode_q == MODE_DEAD && idx_q == AW'(NUM_LAYERS)) begin
            if (!lb_q[0]) r_d = '0;
            if (!lb_q[1]) g_d = '0;
            if (!lb_q[2]) b_d = '0;
        end
        if (!da_q) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    // Mode, fade depth and frame counter only move on frame boundaries.
    always_comb begin
        mode_d  = mode_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (frame_start) begin
            case (mode_q)
                MODE_RUN: begin
                    if (game_over) begin
                        mode_d  = MODE_FADE;
                        shift_d = '0;
                        cnt_d   = '0;
                    end
                end
                MODE_FADE: begin
                    if (!game_over) begin
                        mode_d  = MODE_RUN;
                        shift_d = '0;
                    end else if (cnt_q == CW'(FADE_STEP_FRAMES - 1)) begin
                        cnt_d = '0;
                        if (shift_q == SW'(COLOR_BITS - 1)) begin
                            mode_d  = MODE_DEAD;
                            shift_d = '0;
                        end else begin
                            shift_d = shift_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                MODE_DEAD: begin
                    if (!game_over) mode_d = MODE_RUN;
                end
                default: mode_d = MODE_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_RUN;
            shift_q   <= '0;
            cnt_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            idx_q     <= AW'(NUM_LAYERS);
            da_q      <= 1'b0;
            lb_q      <= '0;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            pix_valid <= 1'b0;
            for (int i = 0; i < NUM_LAYERS; i++) pal_q[i] <= '1;
            pal_q[NUM_LAYERS] <= '0;
        end else begin
            mode_q    <= mode_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            idx_q     <= idx_d;
            da_q      <= display_area;
            lb_q      <= lfsr_q[2:0];
            VGA_R     <= r_d;
            VGA_G     <= g_d;
            VGA_B     <= b_d;
            pix_valid <= da_q;
            for (int i = 0; i <= NUM_LAYERS; i++) begin
                if (pal_we && pal_addr == AW'(i)) pal_q[i] <= pal_data;
            end
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed and random pixel streams compared every cycle against
// a frame/pulse-level reference model of priority, palette, fade and noise behaviour.
module tb_layer_compositor;

    localparam int          NL   = 8;
    localparam int          CB   = 8;
    localparam int          FSF  = 4;
    localparam logic [15:0] TAPS = 16'h8016;
    localparam logic [15:0] SEED = 16'h0F0F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  layer_hit = '0;
    logic [7:0]  noise_mask = '0;
    logic        display_area = 1'b0;
    logic        frame_start = 1'b0;
    logic        game_over = 1'b0;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_addr = '0;
    logic [23:0] pal_data = '0;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        pix_valid;
    logic [1:0]  mode;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [23:0] m_pal [0:NL];
    int          m_mode;
    int          m_pulses;
    logic [15:0] m_lfsr;
    int          s1_idx;
    logic        s1_da;
    logic [2:0]  s1_lb;
    logic [23:0] m_rgb;
    logic        m_pv;

    layer_compositor #(
        .NUM_LAYERS      (NL),
        .COLOR_BITS      (CB),
        .LFSR_WIDTH      (16),
        .LFSR_TAPS       (TAPS),
        .LFSR_SEED       (SEED),
        .FADE_STEP_FRAMES(FSF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .layer_hit   (layer_hit),
        .noise_mask  (noise_mask),
        .display_area(display_area),
        .frame_start (frame_start),
        .game_over   (game_over),
        .pal_we      (pal_we),
        .pal_addr    (pal_addr),
        .pal_data    (pal_data),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .pix_valid   (pix_valid),
        .mode        (mode)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        if (v == 16'h0) return SEED;
        return (v << 1) | 16'($countones(v & TAPS) % 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) m_pal[i] = 24'hFFFFFF;
        m_pal[NL] = 24'h000000;
        m_mode   = 0;
        m_pulses = 0;
        m_lfsr   = SEED;
        s1_idx   = NL;
        s1_da    = 1'b0;
        s1_lb    = 3'b000;
        m_rgb    = 24'h0;
        m_pv     = 1'b0;
    endtask

    // Everything below is evaluated from the pre-edge state, as the hardware sees it.
    task automatic model_edge();
        logic [23:0] c;
        logic [7:0]  r, g, b, eff;
        int          sh;
        c  = m_pal[s1_idx];
        sh = (m_mode == 1) ? m_pulses / FSF : 0;
        r  = c[23:16] >> sh;
        g  = c[15:8] >> sh;
        b  = c[7:0] >> sh;
        if (m_mode == 2 && s1_idx == NL) begin
            if (!s1_lb[0]) r = 8'h0;
            if (!s1_lb[1]) g = 8'h0;
            if (!s1_lb[2]) b = 8'h0;
        end
        if (!s1_da) begin
            r = 8'h0; g = 8'h0; b = 8'h0;
        end
        m_rgb = {r, g, b};
        m_pv  = s1_da;

        eff = layer_hit;
        if (m_mode == 2 && !m_lfsr[0]) eff = layer_hit & ~noise_mask;
        s1_idx = NL;
        for (int i = 0; i < NL; i++) begin
            if (eff[i]) begin
                s1_idx = i;
                break;
            end
        end
        s1_da = display_area;
        s1_lb = m_lfsr[2:0];

        if (pal_we && pal_addr <= NL) m_pal[pal_addr] = pal_data;

        if (frame_start) begin
            case (m_mode)
                0: if (game_over) begin m_mode = 1; m_pulses = 0; end
                1: begin
                    if (!game_over) begin
                        m_mode = 0; m_pulses = 0;
                    end else begin
                        m_pulses++;
                        if (m_pulses == FSF * CB) begin m_mode = 2; m_pulses = 0; end
                    end
                end
                default: if (!game_over) m_mode = 0;
            endcase
        end
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, m_rgb});
        chk("pix_valid", 32'(pix_valid), 32'(m_pv));
        chk("mode", 32'(mode), 32'(m_mode));
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
    endtask

    task automatic pal_write(input logic [3:0] a, input logic [23:0] d);
        pal_we = 1'b1; pal_addr = a; pal_data = d;
        tick();
        pal_we = 1'b0;
    endtask

    initial begin
        model_reset();
        #3;
        chk("reset_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("reset_pv", 32'(pix_valid), 32'h0);
        chk("reset_mode", 32'(mode), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Defaults: black background, white layers
        display_area = 1'b1; layer_hit = 8'h00;
        tick(); tick();
        chk("bg_default", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        layer_hit = 8'h01;
        tick(); tick();
        chk("layer0_white", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFFFFFF);
        chk("pv_high", 32'(pix_valid), 32'h1);

        // Priority and palette, including an out-of-range write that must be ignored
        pal_write(4'd3, 24'h00FF00);
        pal_write(4'd5, 24'hFF0000);
        pal_write(4'd12, 24'($urandom));
        layer_hit = 8'h28;
        tick(); tick();
        chk("prio_28", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h00FF00);
        layer_hit = 8'h20;
        tick(); tick();
        chk("prio_20", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFF0000);
        display_area = 1'b0;
        tick(); tick();
        chk("blank_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("blank_pv", 32'(pix_valid), 32'h0);

        // Same-edge write and read of entry 0
        display_area = 1'b1; layer_hit = 8'h01;
        tick();
        pal_write(4'd0, 24'h123456);
        chk("same_edge_old", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFFFFFF);
        tick();
        chk("same_edge_new", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h123456);

        // Random pixels in RUN
        repeat (200) begin
            layer_hit    = 8'($urandom);
            noise_mask   = 8'($urandom);
            display_area = ($urandom_range(0, 3) != 0);
            pal_we       = ($urandom_range(0, 7) == 0);
            pal_addr     = 4'($urandom_range(0, 15));
            pal_data     = 24'($urandom);
            frame_start  = ($urandom_range(0, 15) == 0);
            tick();
        end
        pal_we = 1'b0; frame_start = 1'b0;

        // Fade stepping
        noise_mask = 8'h00; layer_hit = 8'h01; display_area = 1'b1;
        pal_write(4'd0, 24'hFFFFFF);
        game_over = 1'b1;
        pulse();
        chk("fade_entered", 32'(mode), 32'h1);
        repeat (4) pulse();
        chk("fade_7f", 32'(VGA_R), 32'h7F);
        repeat (4) pulse();
        chk("fade_3f", 32'(VGA_R), 32'h3F);
        repeat (23) pulse();
        chk("fade_last", 32'(mode), 32'h1);
        pulse();
        chk("dead_entered", 32'(mode), 32'h2);

        // DEAD noise on a masked layer, then background gating
        noise_mask = 8'h01; layer_hit = 8'h03;
        pal_write(4'd1, 24'h0000FF);
        repeat (64) tick();
        pal_write(4'd8, 24'hFFFFFF);
        layer_hit = 8'h00;
        repeat (48) tick();

        // Recovery: DEAD and FADE hold until the next frame_start
        layer_hit = 8'h01; game_over = 1'b0;
        tick(); tick(); tick();
        chk("dead_hold", 32'(mode), 32'h2);
        pulse();
        chk("dead_to_run", 32'(mode), 32'h0);
        game_over = 1'b1;
        repeat (7) pulse();
        game_over = 1'b0;
        tick(); tick(); tick();
        chk("fade_hold", 32'(mode), 32'h1);
        pulse();
        chk("fade_to_run", 32'(mode), 32'h0);
        chk("full_bright", 32'(VGA_R), 32'hFF);

        // Lockup recovery
        force dut.lfsr_q = 16'h0;
        m_lfsr = 16'h0;
        #1;
        release dut.lfsr_q;
        tick();
        chk("lfsr_reload", 32'(dut.lfsr_q), 32'(SEED));
        repeat (8) tick();

        // Random everything, game_over mostly held so DEAD is reachable
        repeat (600) begin
            layer_hit    = 8'($urandom);
            noise_mask   = 8'($urandom);
            display_area = ($urandom_range(0, 3) != 0);
            pal_we       = ($urandom_range(0, 15) == 0);
            pal_addr     = 4'($urandom_range(0, 15));
            pal_data     = 24'($urandom);
            frame_start  = ($urandom_range(0, 3) == 0);
            game_over    = ($urandom_range(0, 63) != 0);
            tick();
        end
        pal_we = 1'b0; frame_start = 1'b0; game_over = 1'b0;

        // Asynchronous reset mid-frame
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("async_rst_mode", 32'(mode), 32'h0);
        model_reset();
        #1;
        reset = 1'b0;
        display_area = 1'b1; layer_hit = 8'h01;
        tick(); tick();
        chk("post_rst_white", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFFFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
